alu_scheduler: RTL and testbench
================================

# alu_scheduler

Shares one combinational ALU among `N_REQ` requesters. It round-robin arbitrates valid/ready requests, decodes each winner's `opcode`/`funct7`/`funct3` into a 4-bit ALU operation, and drives the ALU from registered operands. It captures the result and returns it on a single response channel tagged with the requester index. It sits between the issue logic of the execution clusters and the shared ALU datapath.

## Interface
- `N_REQ`, default 4, number of requesters (2..8)
- `XLEN`, default 32, operand/result width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  N_REQ  per-requester request valid
- `req_ready`  out  N_REQ  per-requester accept (one-hot or zero)
- `req_opcode`  in  N_REQ×7  instruction opcode per requester
- `req_funct7`  in  N_REQ×7  funct7 per requester
- `req_funct3`  in  N_REQ×3  funct3 per requester
- `req_a`, `req_b`  in  N_REQ×XLEN  operands per requester
- `alu_op`  out  4  operation to shared ALU
- `alu_a`, `alu_b`  out  XLEN  operands to shared ALU
- `alu_result`  in  XLEN  combinational ALU result
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response accept
- `rsp_id`  out  $clog2(N_REQ)  index of the requester served
- `rsp_result`  out  XLEN  captured result
- `rsp_illegal`  out  1  request decoded to an unsupported operation

## Operation
- Decode rules (opcode 7'b0110011 only, key {funct7,funct3}):
  - ADD 0000000_000 → 0000; SUB 0100000_000 → 0001
  - AND 0000000_111 → 0010; OR 0000000_110 → 0011; XOR 0000000_100 → 0100
  - SLL 0000000_001 → 0111; SRL 0000000_101 → 1000; SRA 0100000_101 → 1001
  - Anything else → 1111 (illegal)
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid`, grant the first set bit at or after `rr_ptr` (wrapping).
  - Assert `req_ready[g]` combinationally in that cycle.
  - Latch g, the decoded op and both operands into the issue registers.
  - Set `rr_ptr` ← (g+1) mod N_REQ.
  - Next state is EXEC, or RESP with `rsp_illegal`=1 and `rsp_result`=0 if the op decoded to 1111.
- EXEC:
  - `alu_op`/`alu_a`/`alu_b` come from the issue registers.
  - Capture `alu_result` into `rsp_result` at the clock edge, then go to RESP.
  - No `req_ready` is asserted.
- RESP:
  - `rsp_valid`=1; `rsp_id`, `rsp_result` and `rsp_illegal` stay stable until `rsp_ready`.
  - On `rsp_ready`, the arbiter may grant a new request in the same cycle (same rules as IDLE → EXEC/RESP); otherwise go to IDLE.
- Requester payloads are sampled only in the granted cycle. A requester deasserting `req_valid` without `req_ready` is legal and loses nothing.
- `req_ready` is never asserted in EXEC, or in RESP without `rsp_ready`.

## Timing
- Reset values (async, on `rst_n` low): state IDLE, `rr_ptr`=0, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_illegal`=0, `alu_op`=1111, `alu_a`=`alu_b`=0.
- Reset mid-EXEC or mid-RESP discards the transaction; no response is produced.
- Latency from grant edge to `rsp_valid`:
  - 2 cycles for a legal op
  - 1 cycle for an illegal op
- Throughput: with `rsp_ready` held high, one legal op every 2 cycles.
- `alu_op` holds 1111 and the ALU operands hold their last values outside EXEC. The ALU path from `alu_*` to `alu_result` must settle within one cycle.
- `req_ready` depends combinationally on `req_valid`, state, `rr_ptr` and `rsp_ready`. There is no combinational path from `req_*` payload to `rsp_*`.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_e` enum (ADD..SRA, ILLEGAL=4'b1111)
  - `OPC_RTYPE`=7'b0110011
  - funct7/funct3 constants
  - `sched_state_e`
- One sub-module, instantiated once on the muxed granted fields: `alu_op_decode`, combinational, inputs {opcode, funct7, funct3}, output `alu_op_e`.
- The round-robin pick is a local function, not a separate module.

## Test plan
- Requester 0 only, ADD a=5, b=3 → `req_ready[0]` in cycle 0; EXEC `alu_op`=0000; `rsp_valid` at cycle 2 with `rsp_id`=0, `rsp_result`=8.
- All four requesters valid continuously, `rsp_ready`=1 → grant order 0,1,2,3,0; one response every 2 cycles; ids in the same order.
- SRA a=32'h8000_0000, b=4 → `alu_op`=1001; `rsp_result`=32'hF800_0000.
- Illegal request: funct7=0100000, funct3=111 → `rsp_valid` at cycle 1 with `rsp_illegal`=1, `rsp_result`=0; `alu_op` never leaves 1111.
- `rsp_ready` low for 5 cycles in RESP while requester 2 is valid → response fields stable, `req_ready`=0; on `rsp_ready`, requester 2 is granted in the same cycle.
- `rst_n` pulsed low during EXEC → all outputs return to reset values; no `rsp_valid`; the next grant starts from requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU scheduler slice.
// ALU op encodings, R-type decode constants and scheduler FSM states.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD     = 4'b0000,
      OP_SUB     = 4'b0001,
      OP_AND     = 4'b0010,
      OP_OR      = 4'b0011,
      OP_XOR     = 4'b0100,
      OP_SLL     = 4'b0111,
      OP_SRL     = 4'b1000,
      OP_SRA     = 4'b1001,
      OP_ILLEGAL = 4'b1111
   } alu_op_e;

   localparam logic [6:0] OPC_RTYPE = 7'b0110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_SR  = 3'b101;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } sched_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational R-type decoder: {opcode, funct7, funct3} -> ALU op.
// Ports: opcode/funct7/funct3 in, op out (OP_ILLEGAL if unsupported).
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [6:0] funct7,
   input  logic [2:0] funct3,
   output alu_op_e    op
);

   always_comb begin
      op = OP_ILLEGAL;
      if (opcode == OPC_RTYPE) begin
         unique case ({funct7, funct3})
            {F7_BASE, F3_ADD}: op = OP_ADD;
            {F7_ALT,  F3_ADD}: op = OP_SUB;
            {F7_BASE, F3_AND}: op = OP_AND;
            {F7_BASE, F3_OR }: op = OP_OR;
            {F7_BASE, F3_XOR}: op = OP_XOR;
            {F7_BASE, F3_SLL}: op = OP_SLL;
            {F7_BASE, F3_SR }: op = OP_SRL;
            {F7_ALT,  F3_SR }: op = OP_SRA;
            default:           op = OP_ILLEGAL;
         endcase
      end
   end

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one combinational ALU among N_REQ requesters.
// Ports: req_* valid/ready request channels, alu_* to/from shared ALU,
// rsp_* single tagged response channel (valid/ready).
module alu_scheduler
   import alu_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int XLEN  = 32
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [N_REQ-1:0]                 req_valid,
   output logic [N_REQ-1:0]                 req_ready,
   input  logic [N_REQ-1:0][6:0]            req_opcode,
   input  logic [N_REQ-1:0][6:0]            req_funct7,
   input  logic [N_REQ-1:0][2:0]            req_funct3,
   input  logic [N_REQ-1:0][XLEN-1:0]       req_a,
   input  logic [N_REQ-1:0][XLEN-1:0]       req_b,
   output logic [3:0]                       alu_op,
   output logic [XLEN-1:0]                  alu_a,
   output logic [XLEN-1:0]                  alu_b,
   input  logic [XLEN-1:0]                  alu_result,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [$clog2(N_REQ)-1:0]         rsp_id,
   output logic [XLEN-1:0]                  rsp_result,
   output logic                             rsp_illegal
);

   localparam int IW = $clog2(N_REQ);

   sched_state_e  state, nstate;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] gnt_idx;
   logic [IW-1:0] iss_id;
   alu_op_e       iss_op;
   alu_op_e       dec_op;
   logic          grant;

   // First valid index at or after p, wrapping. Lowest offset wins,
   // so scan from the far end and let nearer hits overwrite.
   function automatic logic [IW-1:0] rr_pick(
      input logic [N_REQ-1:0] v,
      input logic [IW-1:0]    p
   );
      logic [IW-1:0] idx;
      rr_pick = p;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = IW'((int'(p) + i) % N_REQ);
         if (v[idx]) rr_pick = idx;
      end
   endfunction

   assign gnt_idx = rr_pick(req_valid, rr_ptr);

   alu_op_decode u_dec (
      .opcode (req_opcode[gnt_idx]),
      .funct7 (req_funct7[gnt_idx]),
      .funct3 (req_funct3[gnt_idx]),
      .op     (dec_op)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nstate;
   end

   // rst_n gates grant so no handshake completes while held in reset.
   always_comb begin
      nstate = state;
      grant  = 1'b0;
      case (state)
         S_IDLE: begin
            if (rst_n && |req_valid) begin
               grant  = 1'b1;
               nstate = (dec_op == OP_ILLEGAL) ? S_RESP : S_EXEC;
            end
         end
         S_EXEC: nstate = S_RESP;
         S_RESP: begin
            if (rsp_ready) begin
               if (rst_n && |req_valid) begin
                  grant  = 1'b1;
                  nstate = (dec_op == OP_ILLEGAL) ? S_RESP : S_EXEC;
               end else begin
                  nstate = S_IDLE;
               end
            end
         end
         default: nstate = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      if (grant) req_ready[gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr      <= '0;
         iss_id      <= '0;
         iss_op      <= OP_ILLEGAL;
         alu_a       <= '0;
         alu_b       <= '0;
         rsp_id      <= '0;
         rsp_result  <= '0;
         rsp_illegal <= 1'b0;
      end else begin
         if (grant) begin
            iss_id <= gnt_idx;
            iss_op <= dec_op;
            alu_a  <= req_a[gnt_idx];
            alu_b  <= req_b[gnt_idx];
            rr_ptr <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            // Illegal ops skip the ALU and respond directly.
            if (dec_op == OP_ILLEGAL) begin
               rsp_id      <= gnt_idx;
               rsp_result  <= '0;
               rsp_illegal <= 1'b1;
            end
         end
         if (state == S_EXEC) begin
            rsp_id      <= iss_id;
            rsp_result  <= alu_result;
            rsp_illegal <= 1'b0;
         end
      end
   end

   assign alu_op    = (state == S_EXEC) ? iss_op : OP_ILLEGAL;
   assign rsp_valid = (state == S_RESP);

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed self-checking bench for alu_scheduler with a bench-side ALU.
// Covers reset, single op, round-robin, SRA, illegal, backpressure, reset.
module tb_alu_scheduler;

   localparam int N  = 4;
   localparam int XL = 32;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] F7B = 7'b0000000;
   localparam logic [6:0] F7A = 7'b0100000;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N-1:0][6:0] req_opcode;
   logic [N-1:0][6:0] req_funct7;
   logic [N-1:0][2:0] req_funct3;
   logic [N-1:0][XL-1:0] req_a;
   logic [N-1:0][XL-1:0] req_b;
   logic [3:0]        alu_op;
   logic [XL-1:0]     alu_a;
   logic [XL-1:0]     alu_b;
   logic [XL-1:0]     alu_result;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [1:0]        rsp_id;
   logic [XL-1:0]     rsp_result;
   logic              rsp_illegal;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_scheduler #(.N_REQ(N), .XLEN(XL)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_opcode  (req_opcode),
      .req_funct7  (req_funct7),
      .req_funct3  (req_funct3),
      .req_a       (req_a),
      .req_b       (req_b),
      .alu_op      (alu_op),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_result  (alu_result),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_result  (rsp_result),
      .rsp_illegal (rsp_illegal)
   );

   always_comb begin
      alu_result = '0;
      case (alu_op)
         4'b0000: alu_result = alu_a + alu_b;
         4'b0001: alu_result = alu_a - alu_b;
         4'b0010: alu_result = alu_a & alu_b;
         4'b0011: alu_result = alu_a | alu_b;
         4'b0100: alu_result = alu_a ^ alu_b;
         4'b0111: alu_result = alu_a << alu_b[4:0];
         4'b1000: alu_result = alu_a >> alu_b[4:0];
         4'b1001: alu_result = $signed(alu_a) >>> alu_b[4:0];
         default: alu_result = '0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [6:0] f7,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b);
      req_opcode[i] = RT;
      req_funct7[i] = f7;
      req_funct3[i] = f3;
      req_a[i]      = a;
      req_b[i]      = b;
      req_valid[i]  = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 32'(req_ready), 32'h0);
      chk({tag, "_rspv"}, 32'(rsp_valid), 32'h0);
      chk({tag, "_id"}, 32'(rsp_id), 32'h0);
      chk({tag, "_res"}, rsp_result, 32'h0);
      chk({tag, "_ill"}, 32'(rsp_illegal), 32'h0);
      chk({tag, "_op"}, 32'(alu_op), 32'hF);
      chk({tag, "_a"}, alu_a, 32'h0);
      chk({tag, "_b"}, alu_b, 32'h0);
   endtask

   int ord[6];
   logic [31:0] rres[4];
   logic [3:0]  rops[4];

   initial begin
      rst_n      = 1'b0;
      req_valid  = '0;
      req_opcode = '0;
      req_funct7 = '0;
      req_funct3 = '0;
      req_a      = '0;
      req_b      = '0;
      rsp_ready  = 1'b0;

      // Reset values
      @(negedge clk);
      #1;
      chk_reset_vals("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Requester 0 ADD 5+3
      @(negedge clk);
      set_req(0, F7B, 3'b000, 32'd5, 32'd3);
      #1;
      chk("add_ready", 32'(req_ready), 32'h1);
      chk("add_op_c0", 32'(alu_op), 32'hF);
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("add_op", 32'(alu_op), 32'h0);
      chk("add_a", alu_a, 32'd5);
      chk("add_b", alu_b, 32'd3);
      chk("add_rspv_c1", 32'(rsp_valid), 32'h0);
      @(negedge clk);
      #1;
      chk("add_rspv", 32'(rsp_valid), 32'h1);
      chk("add_id", 32'(rsp_id), 32'h0);
      chk("add_res", rsp_result, 32'd8);
      chk("add_op_c2", 32'(alu_op), 32'hF);
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("add_idle", 32'(rsp_valid), 32'h0);

      // Round robin, all four valid, rsp_ready high
      do_reset();
      ord  = '{0, 1, 2, 3, 0, 1};
      rres = '{32'h63, 32'h0F00, 32'hF00F, 32'h30};
      rops = '{4'h1, 4'h2, 4'h3, 4'h7};
      @(negedge clk);
      set_req(0, F7A, 3'b000, 32'd100, 32'd1);
      set_req(1, F7B, 3'b111, 32'hFF00, 32'h0FF0);
      set_req(2, F7B, 3'b110, 32'hF000, 32'h000F);
      set_req(3, F7B, 3'b001, 32'd3, 32'd4);
      rsp_ready = 1'b1;
      for (int c = 0; c <= 10; c++) begin
         #1;
         if (c % 2 == 0) begin
            chk($sformatf("rr_ready%0d", c), 32'(req_ready),
                32'(1) << ord[c/2]);
            if (c >= 2) begin
               chk($sformatf("rr_rspv%0d", c), 32'(rsp_valid), 32'h1);
               chk($sformatf("rr_id%0d", c), 32'(rsp_id),
                   32'(ord[c/2-1]));
               chk($sformatf("rr_res%0d", c), rsp_result,
                   rres[ord[c/2-1]]);
            end
         end else begin
            chk($sformatf("rr_ready%0d", c), 32'(req_ready), 32'h0);
            chk($sformatf("rr_rspv%0d", c), 32'(rsp_valid), 32'h0);
            chk($sformatf("rr_op%0d", c), 32'(alu_op),
                32'(rops[ord[c/2]]));
         end
         @(negedge clk);
      end

      // SRA on requester 1
      do_reset();
      @(negedge clk);
      set_req(1, F7A, 3'b101, 32'h8000_0000, 32'd4);
      #1;
      chk("sra_ready", 32'(req_ready), 32'h2);
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("sra_op", 32'(alu_op), 32'h9);
      @(negedge clk);
      #1;
      chk("sra_rspv", 32'(rsp_valid), 32'h1);
      chk("sra_id", 32'(rsp_id), 32'h1);
      chk("sra_res", rsp_result, 32'hF800_0000);
      rsp_ready = 1'b1;

      // Illegal on requester 3 (rr_ptr now 2)
      @(negedge clk);
      rsp_ready = 1'b0;
      set_req(3, F7A, 3'b111, 32'd7, 32'd9);
      #1;
      chk("ill_ready", 32'(req_ready), 32'h8);
      chk("ill_op_c0", 32'(alu_op), 32'hF);
      @(negedge clk);
      req_valid = '0;
      set_req(2, F7B, 3'b100, 32'hF0F0, 32'h0FF0);
      #1;
      chk("ill_rspv", 32'(rsp_valid), 32'h1);
      chk("ill_flag", 32'(rsp_illegal), 32'h1);
      chk("ill_res", rsp_result, 32'h0);
      chk("ill_id", 32'(rsp_id), 32'h3);

      // Backpressure: rsp_ready low 5 cycles, requester 2 waiting
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp_rspv%0d", c), 32'(rsp_valid), 32'h1);
         chk($sformatf("bp_id%0d", c), 32'(rsp_id), 32'h3);
         chk($sformatf("bp_ill%0d", c), 32'(rsp_illegal), 32'h1);
         chk($sformatf("bp_res%0d", c), rsp_result, 32'h0);
         chk($sformatf("bp_ready%0d", c), 32'(req_ready), 32'h0);
         chk($sformatf("bp_op%0d", c), 32'(alu_op), 32'hF);
         @(negedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_grant", 32'(req_ready), 32'h4);
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("xor_op", 32'(alu_op), 32'h4);
      @(negedge clk);
      #1;
      chk("xor_rspv", 32'(rsp_valid), 32'h1);
      chk("xor_id", 32'(rsp_id), 32'h2);
      chk("xor_res", rsp_result, 32'hFF00);
      chk("xor_ill", 32'(rsp_illegal), 32'h0);

      // Reset pulse during EXEC
      do_reset();
      @(negedge clk);
      set_req(1, F7B, 3'b000, 32'd20, 32'd22);
      @(negedge clk);
      #1;
      chk("rx_exec_op", 32'(alu_op), 32'h0);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rx");
      @(negedge clk);
      #1;
      chk("rx_hold_rspv", 32'(rsp_valid), 32'h0);
      chk("rx_hold_ready", 32'(req_ready), 32'h0);
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      set_req(0, F7B, 3'b000, 32'd1, 32'd1);
      set_req(2, F7B, 3'b000, 32'd2, 32'd2);
      #1;
      chk("rx_regrant", 32'(req_ready), 32'h1);
      chk("rx_rspv", 32'(rsp_valid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
